// File: rtl/cmp2_sweep_checker.sv
// cmp2_sweep_checker: exhaustive tester for a 2-bit magnitude comparator.
// Drives all 16 input vectors A={a,b}, B={c,d}. Each vector is held for SETTLE
// cycles, and the comparator response is then checked against the expected
// A>B / A==B / A<B result.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   start         request a sweep (level, sampled in IDLE/DONE, ignored in RUN)
//   a, b, c, d    stimulus outputs, {a,b,c,d} = current vector (0 outside RUN)
//   f1, f2, f3    comparator response: A>B, A==B, A<B
//   busy, done    sweep in progress / sweep finished (held until next start)
//   pass          done with no mismatches
//   err_cnt       number of mismatching vectors (0..16)
//   fail_vec      first failing vector {a,b,c,d}, 0 if none
//
// Optional feature: define CMP2_CHK_STOP_ON_ERR_EN to end the sweep at the
// first mismatch.
module cmp2_sweep_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       f1,
  input  logic       f2,
  input  logic       f3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [3:0] fail_vec
);

  localparam int unsigned VEC_W  = 4;
  localparam int unsigned HOLD_W = 4;
  localparam int unsigned ERR_W  = 5;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = ERR_W'(16);
  localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(15);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [VEC_W-1:0]   vec, vec_nxt;
  logic [HOLD_W-1:0]  hold, hold_nxt;
  logic [ERR_W-1:0]   err_nxt;
  logic [VEC_W-1:0]   fail_nxt;
  logic [VEC_W-1:0]   stim;
  logic               gt, eq, lt;
  logic               resp_bad;

  // Expected comparator result for the current vector (unsigned).
  assign gt = (vec[3:2] >  vec[1:0]);
  assign eq = (vec[3:2] == vec[1:0]);
  assign lt = (vec[3:2] <  vec[1:0]);

  // Mismatch defaults to 1 and is cleared only on a clean match, so an
  // unknown response in simulation is counted as a failure.
  always_comb begin
    resp_bad = 1'b1;
    if ((f1 == gt) && (f2 == eq) && (f3 == lt))
      resp_bad = 1'b0;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath update
  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    hold_nxt  = hold;
    err_nxt   = err_cnt;
    fail_nxt  = fail_vec;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          vec_nxt   = '0;
          hold_nxt  = '0;
          err_nxt   = '0;
          fail_nxt  = '0;
        end
      end
      RUN: begin
        if (hold == HOLD_LAST) begin
          // Sampling edge: check response, then move to the next vector.
          hold_nxt = '0;
          if (vec == VEC_LAST) state_nxt = DONE;
          else                 vec_nxt   = vec + VEC_W'(1);
          if (resp_bad) begin
            if (err_cnt < ERR_MAX) err_nxt  = err_cnt + ERR_W'(1);
            if (err_cnt == '0)     fail_nxt = vec;
`ifdef CMP2_CHK_STOP_ON_ERR_EN
            state_nxt = DONE;
`endif
          end
        end else begin
          hold_nxt = hold + HOLD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs, all derived from next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec      <= '0;
      hold     <= '0;
      err_cnt  <= '0;
      fail_vec <= '0;
      stim     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      vec      <= vec_nxt;
      hold     <= hold_nxt;
      err_cnt  <= err_nxt;
      fail_vec <= fail_nxt;
      stim     <= (state_nxt == RUN) ? vec_nxt : '0;
      busy     <= (state_nxt == RUN);
      done     <= (state_nxt == DONE);
      pass     <= (state_nxt == DONE) && (err_nxt == '0);
    end
  end

  assign {a, b, c, d} = stim;

endmodule

// File: tb/tb_cmp2_sweep_checker.sv
// Bench for cmp2_sweep_checker: two instances (SETTLE=1 and SETTLE=3) driven
// by a configurable comparator (golden, f2 stuck-at-0, f1/f3 swapped, random
// per-vector faults). Expected sweep results come from a per-vector
// reference model.
module tb_cmp2_sweep_checker;

  logic clk, rst;
  logic start1, start3;
  logic a1, b1, c1, d1, f11, f21, f31, busy1, done1, pass1;
  logic a3, b3, c3, d3, f13, f23, f33, busy3, done3, pass3;
  logic [4:0] err1, err3;
  logic [3:0] fail1, fail3;

  int mode;
  bit sel;
  logic [2:0] fault_tab [16];
  int checks, failures;

`ifdef CMP2_CHK_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  cmp2_sweep_checker #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c(c1), .d(d1),
    .f1(f11), .f2(f21), .f3(f31), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_vec(fail1));

  cmp2_sweep_checker #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .c(c3), .d(d3),
    .f1(f13), .f2(f23), .f3(f33), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .fail_vec(fail3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal comparator outputs {gt,eq,lt} for vector v.
  function automatic logic [2:0] golden(input logic [3:0] v);
    int ia, ib;
    ia = int'(v[3:2]);
    ib = int'(v[1:0]);
    return {ia > ib, ia == ib, ia < ib};
  endfunction

  // Comparator under test, selected by mode.
  function automatic logic [2:0] resp(input int m, input logic [3:0] v);
    logic [2:0] g;
    g = golden(v);
    case (m)
      1:       return {g[2], 1'b0, g[0]};
      2:       return {g[0], g[1], g[2]};
      3:       return g ^ fault_tab[v];
      default: return g;
    endcase
  endfunction

  always_comb {f11, f21, f31} = resp(mode, {a1, b1, c1, d1});
  always_comb {f13, f23, f33} = resp(mode, {a3, b3, c3, d3});

  logic [3:0] obs_abcd;
  logic       obs_busy, obs_done, obs_pass;
  logic [4:0] obs_err;
  logic [3:0] obs_fail;
  always_comb begin
    obs_abcd = sel ? {a3, b3, c3, d3} : {a1, b1, c1, d1};
    obs_busy = sel ? busy3 : busy1;
    obs_done = sel ? done3 : done1;
    obs_pass = sel ? pass3 : pass1;
    obs_err  = sel ? err3  : err1;
    obs_fail = sel ? fail3 : fail1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    start1 = sel ? 1'b0 : v;
    start3 = sel ? v : 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 32'({obs_abcd, obs_busy, obs_done, obs_pass, obs_err, obs_fail}), 32'd0);
  endtask

  // Runs one sweep and checks stimulus, timing and results against the model.
  // repulse >= 0 re-asserts start while that vector is being driven.
  // abort_at >= 0 asserts reset while that vector is driven and returns.
  task automatic sweep(input int m, input bit use3, input int repulse,
                       input int abort_at, input bit pre_started);
    int settle, n, exp_err, exp_first, exp_len, first_seen;
    mode = m;
    sel = use3;
    settle = use3 ? 3 : 1;
    exp_err = 0;
    exp_first = 0;
    first_seen = 0;
    for (int v = 0; v < 16; v++) begin
      if (first_seen == 0 || !STOP) begin
        if (resp(m, 4'(v)) !== golden(4'(v))) begin
          if (exp_err == 0) exp_first = v;
          exp_err++;
          first_seen = 1;
        end
      end
    end
    exp_len = (STOP && exp_err > 0) ? (exp_first + 1) * settle : 16 * settle;
    if (!pre_started) begin
      @(negedge clk);
      set_start(1'b1);
    end
    @(negedge clk);
    n = 0;
    while (obs_done !== 1'b1 && n < 200) begin
      set_start(1'b0);
      chk("busy_run", 32'(obs_busy), 32'd1);
      chk("stim_vec", 32'(obs_abcd), 32'(n / settle));
      if (abort_at >= 0 && n == abort_at * settle) begin
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        @(negedge clk);
        chk_zero("rst_held");
        rst = 1'b0;
        return;
      end
      if (repulse >= 0 && n == repulse * settle) set_start(1'b1);
      @(negedge clk);
      n++;
    end
    set_start(1'b0);
    chk("sweep_len", 32'(n), 32'(exp_len));
    chk("busy_done", 32'(obs_busy), 32'd0);
    chk("err_cnt", 32'(obs_err), 32'(exp_err));
    chk("fail_vec", 32'(obs_fail), 32'(exp_first));
    chk("pass", 32'(obs_pass), 32'(exp_err == 0));
    chk("stim_idle", 32'(obs_abcd), 32'd0);
    repeat (3) @(negedge clk);
    chk("done_hold", 32'({obs_done, obs_err}), 32'({1'b1, 5'(exp_err)}));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    mode = 0;
    sel = 1'b0;
    for (int i = 0; i < 16; i++) fault_tab[i] = 3'b000;
    rst = 1'b1;
    start1 = 1'b1;
    start3 = 1'b0;
    #12;
    chk_zero("reset_dut1");
    sel = 1'b1;
    chk_zero("reset_dut3");
    sel = 1'b0;
    // start held across reset release is taken at the first edge
    @(negedge clk);
    rst = 1'b0;
    sweep(0, 1'b0, -1, -1, 1'b1);
    sweep(0, 1'b0, -1, -1, 1'b0);
    sweep(1, 1'b0, -1, -1, 1'b0);
    sweep(2, 1'b0, -1, -1, 1'b0);
    sweep(0, 1'b1, -1, -1, 1'b0);
    sweep(0, 1'b0, 5, -1, 1'b0);
    sweep(0, 1'b0, -1, 7, 1'b0);
    sweep(0, 1'b0, -1, -1, 1'b0);
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++)
        fault_tab[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      sweep(3, 1'($urandom_range(0, 1)), (r % 2 == 0) ? int'($urandom_range(0, 15)) : -1, -1, 1'b0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
